// File: rtl/fifo_rd_packer_pkg.sv
// +------------------------------------------------------------------------+
// | Package : fifo_pack_pkg                                                |
// | Shared FSM encodings, default word geometry and fill-width helper.     |
// | Rev     : 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package fifo_pack_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    XFER = 1'b1
  } pack_state_t;

  localparam int C_DATA_WIDTH = 8;
  localparam int C_PACK_NUM   = 4;
  localparam int C_WORD_W     = C_DATA_WIDTH * C_PACK_NUM;

  // Fill count must be able to hold the value PACK_NUM itself.
  function automatic int fill_w(input int pack_num);
    return $clog2(pack_num + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pack_out_reg.sv
// +------------------------------------------------------------------------+
// | Module : pack_out_reg                                                  |
// | Output holding register for the packed word with load/accept handshake.|
// | Optional m_keep mask under FIFO_PACK_FLUSH_EN.                         |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module pack_out_reg #(
  parameter int WIDTH = 32
`ifdef FIFO_PACK_FLUSH_EN
  , parameter int KEEP_W = 4
`endif
) (
  input  logic              rdclk,
  input  logic              rd_rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_data,
`ifdef FIFO_PACK_FLUSH_EN
  input  logic [KEEP_W-1:0] load_keep,
  output logic [KEEP_W-1:0] m_keep,
`endif
  input  logic              m_ready,
  output logic              m_valid,
  output logic [WIDTH-1:0]  m_data
);

  // The owner only raises load when the slot is free or being accepted,
  // so m_data never changes under a stalled beat.
  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
`ifdef FIFO_PACK_FLUSH_EN
      m_keep  <= '0;
`endif
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
`ifdef FIFO_PACK_FLUSH_EN
      m_keep  <= load_keep;
`endif
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// +------------------------------------------------------------------------+
// | Module : fifo_rd_packer                                                |
// | Pops FIFO entries and packs PACK_NUM of them into one valid/ready word.|
// | FIFO_PACK_FLUSH_EN adds m_keep and an idle-timeout partial flush.      |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH    = C_DATA_WIDTH,
  parameter int PACK_NUM      = C_PACK_NUM,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                           rdclk,
  input  logic                           rd_rst_n,
  input  logic                           fifo_empty,
  input  logic [DATA_WIDTH-1:0]          fifo_dout,
  output logic                           fifo_rd_en,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH*PACK_NUM-1:0] m_data,
`ifdef FIFO_PACK_FLUSH_EN
  output logic [PACK_NUM-1:0]            m_keep,
`endif
  output logic [15:0]                    word_cnt
);

  localparam int C_WIDTH_WORD = DATA_WIDTH * PACK_NUM;
  localparam int C_FILL_W     = fill_w(PACK_NUM);

  if (PACK_NUM < 2 || FLUSH_TIMEOUT < 1) begin : g_bad_param
    $error("fifo_rd_packer: PACK_NUM must be >= 2 and FLUSH_TIMEOUT >= 1");
  end

  pack_state_t               r_state;
  pack_state_t               w_state_nxt;
  logic [C_FILL_W-1:0]       r_fill;
  logic                      r_inflight;
  logic [C_WIDTH_WORD-1:0]   r_acc;
  logic [C_FILL_W:0]         w_pending;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_go_xfer;
  logic                      w_load;

  // Entries already landed plus the one still in the FIFO output register.
  assign w_pending  = {1'b0, r_fill} + {{C_FILL_W{1'b0}}, r_inflight};
  assign fifo_rd_en = ~fifo_empty & (r_state == FILL)
                    & (w_pending < (C_FILL_W+1)'(PACK_NUM));
  assign w_pop      = fifo_rd_en & ~fifo_empty;
  assign w_full     = (r_fill == C_FILL_W'(PACK_NUM));

`ifdef FIFO_PACK_FLUSH_EN
  localparam int C_IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

  logic [C_IDLE_W-1:0] r_idle;
  logic [PACK_NUM-1:0] w_keep;
  logic                w_flush;

  // A pop arriving on the timeout cycle wins, so no entry is in flight during XFER.
  assign w_flush   = (r_idle == C_IDLE_W'(FLUSH_TIMEOUT)) & ~w_pop;
  assign w_go_xfer = w_full | w_flush;

  always_comb begin
    w_keep = '0;
    for (int i = 0; i < PACK_NUM; i++) begin
      w_keep[i] = (C_FILL_W'(i) < r_fill);
    end
  end

  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_idle <= '0;
    end else if (w_pop || r_fill == '0 || r_state == XFER) begin
      r_idle <= '0;
    end else if (!r_inflight && fifo_empty && r_idle != C_IDLE_W'(FLUSH_TIMEOUT)) begin
      r_idle <= r_idle + C_IDLE_W'(1);
    end
  end
`else
  assign w_go_xfer = w_full;
`endif

  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_go_xfer) w_state_nxt = XFER;
      end
      XFER: begin
        w_load = ~m_valid | m_ready;
        if (w_load) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Accumulator is cleared on every load so a flushed partial word has zero tails.
  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_fill     <= '0;
      r_inflight <= 1'b0;
      r_acc      <= '0;
      word_cnt   <= '0;
    end else begin
      r_inflight <= w_pop;
      if (w_load) begin
        r_fill <= '0;
        r_acc  <= '0;
      end else if (r_inflight) begin
        for (int i = 0; i < PACK_NUM; i++) begin
          if (r_fill == C_FILL_W'(i)) r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
        end
        r_fill <= r_fill + C_FILL_W'(1);
      end
      if (m_valid && m_ready) word_cnt <= word_cnt + 16'd1;
    end
  end

  pack_out_reg #(
    .WIDTH     (C_WIDTH_WORD)
`ifdef FIFO_PACK_FLUSH_EN
    , .KEEP_W  (PACK_NUM)
`endif
  ) u_out (
    .rdclk     (rdclk),
    .rd_rst_n  (rd_rst_n),
    .load      (w_load),
    .load_data (r_acc),
`ifdef FIFO_PACK_FLUSH_EN
    .load_keep (w_keep),
    .m_keep    (m_keep),
`endif
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
// +------------------------------------------------------------------------+
// | Module : tb_fifo_rd_packer                                             |
// | Directed bench for fifo_rd_packer with a behavioural FIFO on wrclk.    |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_rd_packer;
  import fifo_pack_pkg::*;

  logic                rdclk = 1'b0;
  logic                wrclk = 1'b0;
  logic                rd_rst_n = 1'b0;
  logic                fifo_empty = 1'b1;
  logic [7:0]          fifo_dout = 8'h00;
  logic                fifo_rd_en;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [C_WORD_W-1:0] m_data;
  logic [15:0]         word_cnt;
`ifdef FIFO_PACK_FLUSH_EN
  logic [3:0]          m_keep;
  logic [3:0]          rxk[$];
`endif

  logic [7:0]          fq[$];
  logic [31:0]         rx[$];
  int                  n_cmp = 0;
  int                  n_bad = 0;
  int                  viol  = 0;
  bit                  rnd_done = 1'b0;

  always #5 rdclk = ~rdclk;
  always #7 wrclk = ~wrclk;

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK_NUM(4), .FLUSH_TIMEOUT(16)) dut (
    .rdclk      (rdclk),
    .rd_rst_n   (rd_rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef FIFO_PACK_FLUSH_EN
    .m_keep     (m_keep),
`endif
    .word_cnt   (word_cnt)
  );

  // Behavioural FIFO read side: registered dout, empty refreshed after each rdclk edge.
  always @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) fifo_dout <= 8'h00;
    else if (fifo_rd_en && !fifo_empty) fifo_dout <= fq.pop_front();
  end

  always begin
    @(posedge rdclk);
    #2 fifo_empty = (fq.size() == 0);
  end

  always @(negedge rdclk) begin
    if (rd_rst_n) begin
      if (m_valid && m_ready) begin
        rx.push_back(m_data);
`ifdef FIFO_PACK_FLUSH_EN
        rxk.push_back(m_keep);
`endif
      end
      if (fifo_rd_en && fifo_empty) viol++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rdclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    @(posedge wrclk);
    #1 fq.push_back(b);
  endtask

  task automatic do_reset();
    tick(1);
    rd_rst_n = 1'b0;
    fq.delete();
    tick(3);
    rx.delete();
`ifdef FIFO_PACK_FLUSH_EN
    rxk.delete();
`endif
    rd_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_word(input string tag, input logic [31:0] exp, input logic [3:0] exp_keep = 4'hF);
    int t = 0;
    while (rx.size() == 0 && t < 400) begin
      tick(1);
      t++;
    end
    check_val({tag, "_arrive"}, 32'(rx.size() > 0), 32'd1);
    if (rx.size() > 0) begin
      check_val(tag, rx.pop_front(), exp);
`ifdef FIFO_PACK_FLUSH_EN
      check_val({tag, "_keep"}, 32'(rxk.pop_front()), 32'(exp_keep));
`else
      if (exp_keep == 4'h0) $display("note: keep mask ignored in base build");
`endif
    end
  endtask

  initial begin
    logic [31:0] exp_w[$];
    logic [31:0] w;
    logic [7:0]  b;
    int          t;

    // Reset state
    tick(3);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_m_data", m_data, 32'h0);
    check_val("rst_word_cnt", 32'(word_cnt), 32'd0);
    check_val("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rd_rst_n = 1'b1;
    tick(2);

    // 1: single word
    m_ready = 1'b1;
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    wait_word("t1_word", 32'h44332211);
    tick(3);
    check_val("t1_word_cnt", 32'(word_cnt), 32'd1);

    // 2: backpressure holds one word, accumulator fills once, rest stays queued
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) wr(8'(i));
    tick(40);
    check_val("t2_valid_held", 32'(m_valid), 32'd1);
    check_val("t2_data_held", m_data, 32'h03020100);
    check_val("t2_fifo_left", 32'(fq.size()), 32'd4);
    check_val("t2_rd_en_off", 32'(fifo_rd_en), 32'd0);
    tick(10);
    check_val("t2_data_stable", m_data, 32'h03020100);
    check_val("t2_no_accept", 32'(rx.size()), 32'd0);
    m_ready = 1'b1;
    wait_word("t2_w0", 32'h03020100);
    wait_word("t2_w1", 32'h07060504);
    wait_word("t2_w2", 32'h0B0A0908);
    tick(3);
    check_val("t2_word_cnt", 32'(word_cnt), 32'd3);

`ifndef FIFO_PACK_FLUSH_EN
    // 3: partial word is held with no timeout
    wr(8'h31); wr(8'h32); wr(8'h33);
    tick(50);
    check_val("t3_no_valid", 32'(m_valid), 32'd0);
    check_val("t3_no_word", 32'(rx.size()), 32'd0);
    wr(8'h34);
    wait_word("t3_word", 32'h34333231);
`endif

    // 4: reset mid-word discards partial data and clears the counter
    wr(8'h55); wr(8'h66);
    tick(10);
    rd_rst_n = 1'b0;
    fq.delete();
    #1;
    check_val("t4_rst_valid", 32'(m_valid), 32'd0);
    check_val("t4_rst_cnt", 32'(word_cnt), 32'd0);
    tick(2);
    rx.delete();
`ifdef FIFO_PACK_FLUSH_EN
    rxk.delete();
`endif
    rd_rst_n = 1'b1;
    tick(1);
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    wait_word("t4_word", 32'hA4A3A2A1);

`ifdef FIFO_PACK_FLUSH_EN
    // 5: idle timeout flushes a partial word
    do_reset();
    m_ready = 1'b1;
    wr(8'hAA); wr(8'hBB);
    tick(10);
    check_val("t5_not_yet", 32'(rx.size()), 32'd0);
    wait_word("t5_flush", 32'h0000BBAA, 4'b0011);
`endif

    // 6: random stream with random backpressure
    do_reset();
    w = '0;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom);
      w = {b, w[31:8]};
      if (i % 4 == 3) exp_w.push_back(w);
      fq.push_back(b);
    end
    fork
      while (!rnd_done) begin
        @(posedge rdclk);
        #1 m_ready = 1'($urandom_range(0, 1));
      end
    join_none
    t = 0;
    while (rx.size() < 16 && t < 3000) begin
      tick(1);
      t++;
    end
    rnd_done = 1'b1;
    tick(3);
    check_val("t6_count", 32'(rx.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("t6_w%0d", k), (rx.size() > 0) ? rx.pop_front() : 32'hxxxxxxxx, exp_w[k]);
    end
    check_val("t6_word_cnt", 32'(word_cnt), 32'd16);
    check_val("rd_en_while_empty", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
